// File: rtl/ftoi_issue_ctrl.sv
// rtl/ftoi_issue_ctrl.sv - round-robin issue and in-order writeback around a fixed-latency float-to-int unit
module ftoi_issue_ctrl #(
    parameter int NUM_REQ   = 2,
    parameter int TAG_W     = 4,
    parameter int LAT       = 2,
    parameter int OUT_DEPTH = 4,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*32-1:0]    req_operand,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [31:0]              fu_operand,
    input  logic [31:0]              fu_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic [TAG_W-1:0]         rsp_tag
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam logic [ID_W:0]    NREQ_C  = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(OUT_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(OUT_DEPTH);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LAT-1:0]   trk_vld_q;
    logic [ID_W-1:0]  trk_id_q  [LAT];
    logic [TAG_W-1:0] trk_tag_q [LAT];

    logic [31:0]      fifo_data_q [OUT_DEPTH];
    logic [ID_W-1:0]  fifo_id_q   [OUT_DEPTH];
    logic [TAG_W-1:0] fifo_tag_q  [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W:0]   inflight;
    logic [CNT_W:0]   occupancy;
    logic             issue_ok;
    logic             found;
    logic             accept;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W:0]    scan;
    logic [TAG_W-1:0] acc_tag;
    logic             push;
    logic             pop;

    // Every slot already promised to an in-flight op or held in the FIFO is unavailable.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + (CNT_W+1)'(trk_vld_q[i]);
        end
        occupancy = {1'b0, count_q} + inflight;
        issue_ok  = rst_n && !flush && (occupancy < DEPTH_C);
    end

    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        scan     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan >= NREQ_C) begin
                scan = scan - NREQ_C;
            end
            if (!found && req_valid[scan[ID_W-1:0]]) begin
                found    = 1'b1;
                grant_id = scan[ID_W-1:0];
            end
        end
    end

    assign accept     = found && issue_ok;
    assign req_ready  = accept ? (NUM_REQ'(1) << grant_id) : '0;
    assign fu_operand = accept ? req_operand[32*grant_id +: 32] : '0;
    assign acc_tag    = req_tag[TAG_W*grant_id +: TAG_W];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Tracking line mirrors the unit pipeline; flush kills the valids of ops still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                trk_id_q[i]  <= '0;
                trk_tag_q[i] <= '0;
            end
        end else begin
            trk_vld_q[0] <= accept;
            trk_id_q[0]  <= grant_id;
            trk_tag_q[0] <= acc_tag;
            for (int i = 1; i < LAT; i++) begin
                trk_vld_q[i] <= trk_vld_q[i-1] && !flush;
                trk_id_q[i]  <= trk_id_q[i-1];
                trk_tag_q[i] <= trk_tag_q[i-1];
            end
        end
    end

    assign push = trk_vld_q[LAT-1] && !flush;
    assign pop  = rsp_valid && rsp_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_id_q[i]   <= '0;
                fifo_tag_q[i]  <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= fu_result;
                fifo_id_q[wr_ptr_q]   <= trk_id_q[LAT-1];
                fifo_tag_q[wr_ptr_q]  <= trk_tag_q[LAT-1];
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rsp_valid = (count_q != '0);
    assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign rsp_id    = rsp_valid ? fifo_id_q[rd_ptr_q]   : '0;
    assign rsp_tag   = rsp_valid ? fifo_tag_q[rd_ptr_q]  : '0;

    // The unit cannot stall, so a result landing on a full FIFO means the credit logic is broken.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && (count_q == FULL_C)));

endmodule

// File: tb/tb_ftoi_issue_ctrl.sv
// tb/tb_ftoi_issue_ctrl.sv - randomized and directed checks of ftoi_issue_ctrl against an occupancy/queue model
module tb_ftoi_issue_ctrl;
    localparam int NUM_REQ   = 2;
    localparam int TAG_W     = 4;
    localparam int LAT       = 2;
    localparam int OUT_DEPTH = 4;
    localparam int ID_W      = 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*32-1:0]    req_operand;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [31:0]              fu_operand;
    logic [31:0]              fu_result;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [31:0]              rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic [TAG_W-1:0]         rsp_tag;

    always #5 clk = ~clk;

    ftoi_issue_ctrl #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .LAT(LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_operand(req_operand), .req_tag(req_tag),
        .fu_operand(fu_operand), .fu_result(fu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_tag(rsp_tag)
    );

    function automatic logic [31:0] f2i(input logic [31:0] f);
        int e;
        logic [31:0] mag;
        e = int'(f[30:23]) - 127;
        if (e < 0) return 32'h0;
        if (e >= 31) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        mag = {8'h0, 1'b1, f[22:0]};
        if (e >= 23) mag = mag << (e - 23);
        else         mag = mag >> (23 - e);
        return f[31] ? -mag : mag;
    endfunction

    // Conversion unit: result for the operand sampled at an edge appears LAT-1 edges later.
    logic [31:0] fu_pipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        fu_pipe[0] <= f2i(fu_operand);
        for (int i = 1; i < LAT; i++) fu_pipe[i] <= fu_pipe[i-1];
    end
    assign fu_result = fu_pipe[LAT-1];

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        int               due;
    } op_t;

    op_t exp_q[$];
    int  m_ptr, m_out, cyc;
    int  total = 0;
    int  bad   = 0;

    logic [NUM_REQ-1:0] d_valid;
    logic [31:0]        d_op  [NUM_REQ];
    logic [TAG_W-1:0]   d_tag [NUM_REQ];
    logic               d_rr, d_flush;

    logic [NUM_REQ-1:0] exp_ready, obs_ready;
    logic [31:0]        exp_fu, obs_fu, obs_data;
    logic               exp_rv, obs_rv;
    op_t                exp_head;
    logic [ID_W-1:0]    obs_id;
    logic [TAG_W-1:0]   obs_tag;

    logic [31:0] ftab [8] = '{32'h40490FDB, 32'hC0000000, 32'h42C80000, 32'h3F800000,
                              32'h40A00000, 32'h3F000000, 32'hC0F80000, 32'h4E6E6B28};

    task automatic model_reset();
        exp_q.delete();
        m_ptr = 0;
        m_out = 0;
        cyc   = 0;
    endtask

    task automatic idle();
        d_valid = '0;
        d_rr    = 1'b1;
        d_flush = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d_op[i]  = '0;
            d_tag[i] = '0;
        end
    endtask

    task automatic apply_reset();
        req_valid = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        model_reset();
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, sample 1ns later, then let the model take the coming edge.
    task automatic tick();
        int g;
        @(negedge clk);
        req_valid = d_valid;
        flush     = d_flush;
        rsp_ready = d_rr;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_operand[32*i +: 32]     = d_op[i];
            req_tag[TAG_W*i +: TAG_W]   = d_tag[i];
        end
        #1;
        g = -1;
        if (!d_flush && m_out < OUT_DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && d_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_fu = (g >= 0) ? d_op[g] : 32'h0;
        exp_rv = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        if (exp_rv) exp_head = exp_q[0];
        obs_ready = req_ready;
        obs_fu    = fu_operand;
        obs_rv    = rsp_valid;
        obs_data  = rsp_data;
        obs_id    = rsp_id;
        obs_tag   = rsp_tag;
        if (d_flush) begin
            exp_q.delete();
            m_out = 0;
        end else begin
            if (exp_rv && d_rr) begin
                void'(exp_q.pop_front());
                m_out--;
            end
            if (g >= 0) begin
                exp_q.push_back('{id: g[ID_W-1:0], tag: d_tag[g], data: f2i(d_op[g]), due: cyc + LAT + 1});
                m_out++;
                m_ptr = (g + 1) % NUM_REQ;
            end
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        req_operand = {NUM_REQ{32'h3F800000}};
        req_tag     = '1;
        @(negedge clk);
        #1;
        total++; if (req_ready !== '0)  begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (fu_operand !== 32'h0) begin bad++; $display("FAIL reset_fu_operand: got %h want 0", fu_operand); end
        total++; if ({rsp_data, rsp_id, rsp_tag} !== '0) begin
            bad++; $display("FAIL reset_rsp_fields: got data=%h id=%0d tag=%0d want 0", rsp_data, rsp_id, rsp_tag);
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        d_valid = 2'b01; d_op[0] = 32'h40490FDB; d_tag[0] = 4'd5; d_rr = 1'b1;
        tick();
        total++; if (obs_ready !== 2'b01) begin bad++; $display("FAIL single_ready: got %b want 01", obs_ready); end
        total++; if (obs_fu !== 32'h40490FDB) begin bad++; $display("FAIL single_fu_operand: got %h want 40490fdb", obs_fu); end
        idle();
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++; if (obs_rv !== (c == 3)) begin bad++; $display("FAIL single_rsp_valid c%0d: got %b want %b", c, obs_rv, c == 3); end
            if (c == 3) begin
                total++; if ({obs_data, obs_id, obs_tag} !== {32'd3, 1'b0, 4'd5}) begin
                    bad++; $display("FAIL single_rsp: got data=%h id=%0d tag=%0d want 3/0/5", obs_data, obs_id, obs_tag);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int n_rsp;
        logic [1:0] pat;
        apply_reset();
        n_rsp = 0;
        d_valid = 2'b11; d_rr = 1'b1;
        d_op[0] = 32'hC0000000; d_tag[0] = 4'd1;
        d_op[1] = 32'h42C80000; d_tag[1] = 4'd2;
        for (int c = 0; c < 16; c++) begin
            if (c == 12) d_valid = '0;
            tick();
            pat = (c >= 12) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            total++; if (obs_ready !== pat) begin bad++; $display("FAIL fair_grant c%0d: got %b want %b", c, obs_ready, pat); end
            if (c >= 3 && c < 15) begin
                total++; if (obs_rv !== 1'b1) begin bad++; $display("FAIL b2b_rsp_valid c%0d: got %b want 1", c, obs_rv); end
            end
            if (obs_rv === 1'b1) begin
                total++;
                if (obs_id !== n_rsp[0] || obs_data !== (n_rsp[0] ? 32'd100 : 32'hFFFFFFFE)) begin
                    bad++; $display("FAIL fair_rsp #%0d: got id=%0d data=%h want id=%0d data=%h", n_rsp, obs_id, obs_data,
                                    n_rsp[0], n_rsp[0] ? 32'd100 : 32'hFFFFFFFE);
                end
                n_rsp++;
            end
        end
        total++; if (n_rsp !== 12) begin bad++; $display("FAIL fair_rsp_count: got %0d want 12", n_rsp); end
    endtask

    task automatic test_backpressure();
        int acc, n_rsp;
        apply_reset();
        acc = 0; n_rsp = 0;
        d_valid = 2'b01; d_rr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            d_op[0] = ftab[$urandom_range(0, 7)]; d_tag[0] = acc[TAG_W-1:0];
            tick();
            if (obs_ready[0] === 1'b1) acc++;
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL bp_ready c%0d: got %b want %b", c, obs_ready, exp_ready); end
        end
        total++; if (acc !== OUT_DEPTH) begin bad++; $display("FAIL bp_accepts: got %0d want %0d", acc, OUT_DEPTH); end
        d_rr = 1'b1;
        tick();
        total++; if ({obs_rv, obs_ready} !== 3'b100) begin bad++; $display("FAIL bp_pop_cycle: got rv=%b ready=%b want 1/00", obs_rv, obs_ready); end
        d_rr = 1'b0; d_tag[0] = 4'd7;
        tick();
        total++; if (obs_ready !== 2'b01) begin bad++; $display("FAIL bp_credit_back: got %b want 01", obs_ready); end
        tick();
        total++; if (obs_ready !== 2'b00) begin bad++; $display("FAIL bp_full_again: got %b want 00", obs_ready); end
        d_valid = '0; d_rr = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            total++; if (obs_rv !== exp_rv) begin bad++; $display("FAIL bp_drain_valid c%0d: got %b want %b", c, obs_rv, exp_rv); end
            if (exp_rv && obs_rv === 1'b1) begin
                n_rsp++;
                total++; if ({obs_data, obs_id, obs_tag} !== {exp_head.data, exp_head.id, exp_head.tag}) begin
                    bad++; $display("FAIL bp_drain_rsp c%0d: got %h/%0d/%0d want %h/%0d/%0d", c, obs_data, obs_id, obs_tag,
                                    exp_head.data, exp_head.id, exp_head.tag);
                end
            end
        end
        total++; if (n_rsp !== OUT_DEPTH) begin bad++; $display("FAIL bp_drain_count: got %0d want %0d", n_rsp, OUT_DEPTH); end
    endtask

    task automatic test_flush();
        apply_reset();
        d_rr = 1'b1; d_valid = 2'b01;
        d_op[0] = 32'h42C80000; d_tag[0] = 4'd1; tick();
        d_op[0] = 32'hC0000000; d_tag[0] = 4'd2; tick();
        d_flush = 1'b1;
        tick();
        total++; if (obs_ready !== 2'b00) begin bad++; $display("FAIL flush_ready: got %b want 00", obs_ready); end
        d_flush = 1'b0; d_op[0] = 32'h40A00000; d_tag[0] = 4'd9;
        tick();
        total++; if (obs_ready !== 2'b01) begin bad++; $display("FAIL flush_reissue: got %b want 01", obs_ready); end
        d_valid = '0;
        for (int c = 4; c < 9; c++) begin
            tick();
            total++; if (obs_rv !== (c == 6)) begin bad++; $display("FAIL flush_rsp_valid c%0d: got %b want %b", c, obs_rv, c == 6); end
            if (c == 6) begin
                total++; if ({obs_data, obs_tag} !== {32'd5, 4'd9}) begin
                    bad++; $display("FAIL flush_rsp: got data=%h tag=%0d want 5/9", obs_data, obs_tag);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        d_rr = 1'b0; d_valid = 2'b01;
        for (int c = 0; c < 4; c++) begin
            d_op[0] = ftab[c]; d_tag[0] = c[TAG_W-1:0];
            tick();
        end
        total++; if (obs_rv !== 1'b1) begin bad++; $display("FAIL areset_fifo_nonempty: got %b want 1", obs_rv); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({req_ready, rsp_valid, fu_operand, rsp_data, rsp_id, rsp_tag} !== '0) begin
            bad++; $display("FAIL areset_outputs: got ready=%b rv=%b fu=%h data=%h id=%0d tag=%0d want all 0",
                            req_ready, rsp_valid, fu_operand, rsp_data, rsp_id, rsp_tag);
        end
        model_reset();
        idle();
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        d_valid = 2'b01; d_op[0] = 32'h3F800000; d_tag[0] = 4'd3;
        tick();
        total++; if (obs_ready !== 2'b01) begin bad++; $display("FAIL areset_first_issue: got %b want 01", obs_ready); end
        d_valid = '0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++; if (obs_rv !== (c == 3)) begin bad++; $display("FAIL areset_rsp_valid c%0d: got %b want %b", c, obs_rv, c == 3); end
            if (c == 3) begin
                total++; if ({obs_data, obs_id, obs_tag} !== {32'd1, 1'b0, 4'd3}) begin
                    bad++; $display("FAIL areset_rsp: got %h/%0d/%0d want 1/0/3", obs_data, obs_id, obs_tag);
                end
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if (c < 580) begin
                d_valid = NUM_REQ'($urandom);
                d_rr    = ($urandom_range(0, 3) != 0);
                d_flush = ($urandom_range(0, 50) == 0);
                for (int i = 0; i < NUM_REQ; i++) begin
                    d_op[i]  = $urandom_range(0, 3) == 0 ? $urandom : ftab[$urandom_range(0, 7)];
                    d_tag[i] = TAG_W'($urandom);
                end
            end else begin
                idle();
            end
            tick();
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rand_ready c%0d: got %b want %b", c, obs_ready, exp_ready); end
            total++; if (obs_fu !== exp_fu) begin bad++; $display("FAIL rand_fu_operand c%0d: got %h want %h", c, obs_fu, exp_fu); end
            total++; if (obs_rv !== exp_rv) begin bad++; $display("FAIL rand_rsp_valid c%0d: got %b want %b", c, obs_rv, exp_rv); end
            if (exp_rv) begin
                total++; if ({obs_data, obs_id, obs_tag} !== {exp_head.data, exp_head.id, exp_head.tag}) begin
                    bad++; $display("FAIL rand_rsp c%0d: got %h/%0d/%0d want %h/%0d/%0d", c, obs_data, obs_id, obs_tag,
                                    exp_head.data, exp_head.id, exp_head.tag);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
